// File: rtl/ball_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ball_ctrl
// Purpose  : Single-ball animator with full game flow. It moves the ball once
//            per animation strobe and reflects it off the walls, the paddle
//            and an N-block brick field. It also runs serve, lives, score,
//            the sticky per-brick cleared flags and the win/lose decision.
// Ports    : i_clk, i_rst_n (sync, active-low), i_mode, i_serve, i_ani_stb,
//            i_pad_x1/i_pad_x2 (paddle edges), i_com (paddle motion),
//            i_hit (2 bits per brick) ->
//            o_x/o_y (registered centre), o_x1/o_x2/o_y1/o_y2 (edges),
//            o_cleared, o_score, o_lives, o_state, o_win, o_lose.
// Options  : SPEED_RAMP_EN - every paddle hit raises the step by 1, up to
//            MAX_SPEED. When it is undefined, the step is fixed at SPEED0.
// Revision : 1.0 - initial release
// ============================================================================
module ball_ctrl #(
  parameter int N_BLOCKS        = 22,
  parameter int H_SIZE          = 8,
  parameter int D_WIDTH         = 640,
  parameter int D_HEIGHT        = 480,
  parameter int IX              = 320,
  parameter int IY              = 240,
  parameter int PY              = 440,
  parameter int PH              = 10,
  parameter int SPEED0          = 2,
  parameter int MAX_SPEED       = 7,
  parameter int LIVES           = 3,
  parameter int SCORE_PER_BLOCK = 5
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_mode,
  input  logic                  i_serve,
  input  logic                  i_ani_stb,
  input  logic [11:0]           i_pad_x1,
  input  logic [11:0]           i_pad_x2,
  input  logic [1:0]            i_com,
  input  logic [2*N_BLOCKS-1:0] i_hit,
  output logic [11:0]           o_x,
  output logic [11:0]           o_y,
  output logic [11:0]           o_x1,
  output logic [11:0]           o_x2,
  output logic [11:0]           o_y1,
  output logic [11:0]           o_y2,
  output logic [N_BLOCKS-1:0]   o_cleared,
  output logic [15:0]           o_score,
  output logic [3:0]            o_lives,
  output logic [2:0]            o_state,
  output logic                  o_win,
  output logic                  o_lose
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_WON   = 3'd3,
    ST_LOST  = 3'd4
  } state_t;

  localparam logic [11:0] C_H        = 12'(H_SIZE);
  localparam logic [11:0] C_IX       = 12'(IX);
  localparam logic [11:0] C_IY       = 12'(IY);
  localparam logic [11:0] C_X_LO     = 12'(H_SIZE + 1);
  localparam logic [11:0] C_X_HI     = 12'(D_WIDTH - H_SIZE - 1);
  localparam logic [11:0] C_Y_LO     = 12'(H_SIZE + 1);
  localparam logic [11:0] C_X_MAX    = 12'(D_WIDTH - 1 - H_SIZE);
  localparam logic [11:0] C_BOTTOM   = 12'(D_HEIGHT - 1);
  localparam logic [11:0] C_PY_TOP   = 12'(PY);
  localparam logic [11:0] C_PY_BOT   = 12'(PY + PH);
  localparam logic [3:0]  C_LIVES    = 4'(LIVES);
  localparam logic [31:0] C_PTS      = 32'(SCORE_PER_BLOCK);
  // The serve step never starts above the ceiling.
  localparam logic [3:0]  C_MAX_STEP = 4'(MAX_SPEED);
  localparam logic [3:0]  C_STEP0    = (SPEED0 > MAX_SPEED) ? 4'(MAX_SPEED) : 4'(SPEED0);

  // Direction encoding: x_dir 1 = right (+x), y_dir 1 = down (+y).
  state_t                state_q, state_d;
  logic [11:0]           x_q, x_d, y_q, y_d;
  logic                  x_dir_q, x_dir_d, y_dir_q, y_dir_d;
  logic [N_BLOCKS-1:0]   cleared_q, cleared_d;
  logic [15:0]           score_q, score_d;
  logic [3:0]            lives_q, lives_d;
  logic [15:0]           cnt_q, cnt_d;
  logic [3:0]            w_speed;

`ifdef SPEED_RAMP_EN
  logic [3:0]            speed_q, speed_d;
  assign w_speed = speed_q;
`else
  assign w_speed = C_STEP0;
`endif

  // Edge outputs are derived from the registered centre with 12-bit wrap.
  assign o_x       = x_q;
  assign o_y       = y_q;
  assign o_x1      = x_q - C_H;
  assign o_x2      = x_q + C_H;
  assign o_y1      = y_q - C_H;
  assign o_y2      = y_q + C_H;
  assign o_cleared = cleared_q;
  assign o_score   = score_q;
  assign o_lives   = lives_q;
  assign o_state   = state_q;
  assign o_win     = (state_q == ST_WON);
  assign o_lose    = (state_q == ST_LOST);

  // Only hits on bricks that are still standing count.
  logic [N_BLOCKS-1:0] w_hit_y, w_hit_x, w_new_hit;
  for (genvar k = 0; k < N_BLOCKS; k++) begin : g_hit
    assign w_hit_y[k] = i_hit[2*k]   & ~cleared_q[k];
    assign w_hit_x[k] = i_hit[2*k+1] & ~cleared_q[k];
  end
  assign w_new_hit = w_hit_x | w_hit_y;

  logic [7:0]  w_new_cnt;
  logic [31:0] w_score_sum;
  always_comb begin
    w_new_cnt = 8'd0;
    for (int k = 0; k < N_BLOCKS; k++) begin
      w_new_cnt = w_new_cnt + 8'(w_new_hit[k]);
    end
    w_score_sum = 32'(score_q) + C_PTS * 32'(w_new_cnt);
  end

  logic w_pad_hit, w_bottom;
  assign w_pad_hit = y_dir_q && (o_y2 >= C_PY_TOP) && (o_y2 <= C_PY_BOT) &&
                     (o_x1 <= i_pad_x2) && (o_x2 >= i_pad_x1);
  assign w_bottom  = (o_y2 >= C_BOTTOM);

  // Brick flips are applied first. Paddle and wall rules then overwrite
  // the same axis. The wall has the final say, so the ball cannot be pushed
  // out of the playfield.
  logic w_x_dir_n, w_y_dir_n;
  always_comb begin
    w_x_dir_n = x_dir_q ^ (|w_hit_x);
    w_y_dir_n = y_dir_q ^ (|w_hit_y);
    if (w_pad_hit) begin
      w_y_dir_n = 1'b0;
      if (i_com == 2'b01) w_x_dir_n = 1'b1;
      if (i_com == 2'b10) w_x_dir_n = 1'b0;
    end
    if (x_q <= C_X_LO) w_x_dir_n = 1'b1;
    if (x_q >= C_X_HI) w_x_dir_n = 1'b0;
    if (y_q <= C_Y_LO) w_y_dir_n = 1'b1;
  end

  // Step with the updated directions and clamp to the playfield.
  logic [11:0] w_speed12, w_x_step, w_y_step;
  assign w_speed12 = {8'd0, w_speed};
  always_comb begin
    if (w_x_dir_n) begin
      w_x_step = x_q + w_speed12;
      if (w_x_step > C_X_MAX) w_x_step = C_X_MAX;
    end else if (x_q < C_H + w_speed12) begin
      w_x_step = C_H;
    end else begin
      w_x_step = x_q - w_speed12;
    end
    if (w_y_dir_n) begin
      w_y_step = y_q + w_speed12;
    end else if (y_q < C_H + w_speed12) begin
      w_y_step = C_H;
    end else begin
      w_y_step = y_q - w_speed12;
    end
  end

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    x_dir_d   = x_dir_q;
    y_dir_d   = y_dir_q;
    cleared_d = cleared_q;
    score_d   = score_q;
    lives_d   = lives_q;
    cnt_d     = cnt_q + 16'd1;
`ifdef SPEED_RAMP_EN
    speed_d   = speed_q;
`endif
    if (!i_mode || state_q == ST_IDLE) begin
      x_d       = C_IX;
      y_d       = C_IY;
      cleared_d = '0;
      score_d   = 16'd0;
      lives_d   = C_LIVES;
`ifdef SPEED_RAMP_EN
      speed_d   = C_STEP0;
`endif
      state_d   = i_mode ? ST_SERVE : ST_IDLE;
    end else begin
      case (state_q)
        ST_SERVE: begin
          x_d     = C_IX;
          y_d     = C_IY;
          y_dir_d = 1'b0;
`ifdef SPEED_RAMP_EN
          speed_d = C_STEP0;
`endif
          if (i_serve) begin
            x_dir_d = cnt_q[0];
            state_d = ST_PLAY;
          end
        end
        ST_PLAY: begin
          if (i_ani_stb) begin
            cleared_d = cleared_q | w_new_hit;
            score_d   = (w_score_sum > 32'h0000_FFFF) ? 16'hFFFF : w_score_sum[15:0];
            x_dir_d   = w_x_dir_n;
            y_dir_d   = w_y_dir_n;
`ifdef SPEED_RAMP_EN
            if (w_pad_hit && speed_q < C_MAX_STEP) speed_d = speed_q + 4'd1;
`endif
            // A finished brick field beats a same-strobe bottom loss.
            if (&cleared_d) begin
              state_d = ST_WON;
            end else if (w_bottom) begin
              lives_d = lives_q - 4'd1;
              if (lives_q == 4'd1) begin
                state_d = ST_LOST;
              end else begin
                state_d = ST_SERVE;
                x_d     = C_IX;
                y_d     = C_IY;
              end
            end else begin
              x_d = w_x_step;
              y_d = w_y_step;
            end
          end
        end
        ST_WON, ST_LOST: begin
          if (i_serve) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      x_q       <= C_IX;
      y_q       <= C_IY;
      x_dir_q   <= 1'b0;
      y_dir_q   <= 1'b0;
      cleared_q <= '0;
      score_q   <= 16'd0;
      lives_q   <= C_LIVES;
      cnt_q     <= 16'd0;
`ifdef SPEED_RAMP_EN
      speed_q   <= C_STEP0;
`endif
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      x_dir_q   <= x_dir_d;
      y_dir_q   <= y_dir_d;
      cleared_q <= cleared_d;
      score_q   <= score_d;
      lives_q   <= lives_d;
      cnt_q     <= cnt_d;
`ifdef SPEED_RAMP_EN
      speed_q   <= speed_d;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ball_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ball_ctrl
// Purpose  : Scoreboard bench for ball_ctrl. The driver advances a
//            behavioural game model once per cycle and queues the expected
//            outputs. The monitor compares those outputs after each edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ball_ctrl;
  localparam int NB = 22;
  localparam int H  = 8;
  localparam int S_IDLE = 0, S_SERVE = 1, S_PLAY = 2, S_WON = 3, S_LOST = 4;

  logic              clk = 1'b0;
  logic              i_rst_n = 1'b0, i_mode = 1'b0, i_serve = 1'b0, i_ani_stb = 1'b0;
  logic [11:0]       i_pad_x1 = '0, i_pad_x2 = '0;
  logic [1:0]        i_com = '0;
  logic [2*NB-1:0]   i_hit = '0;
  logic [11:0]       o_x, o_y, o_x1, o_x2, o_y1, o_y2;
  logic [NB-1:0]     o_cleared;
  logic [15:0]       o_score;
  logic [3:0]        o_lives;
  logic [2:0]        o_state;
  logic              o_win, o_lose;

  always #5 clk = ~clk;

  ball_ctrl dut (
    .i_clk(clk), .i_rst_n(i_rst_n), .i_mode(i_mode), .i_serve(i_serve),
    .i_ani_stb(i_ani_stb), .i_pad_x1(i_pad_x1), .i_pad_x2(i_pad_x2),
    .i_com(i_com), .i_hit(i_hit), .o_x(o_x), .o_y(o_y), .o_x1(o_x1),
    .o_x2(o_x2), .o_y1(o_y1), .o_y2(o_y2), .o_cleared(o_cleared),
    .o_score(o_score), .o_lives(o_lives), .o_state(o_state),
    .o_win(o_win), .o_lose(o_lose)
  );

  typedef struct packed {
    logic [11:0]   x;
    logic [11:0]   y;
    logic [NB-1:0] clr;
    logic [15:0]   score;
    logic [3:0]    lives;
    logic [2:0]    st;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  // Game model: positions as plain integers, directions as +1/-1.
  int       m_state, m_x, m_y, m_dx, m_dy, m_lives, m_score, m_speed, m_cnt;
  bit [NB-1:0] m_clr;

  function automatic void model_idle();
    m_x = 320; m_y = 240; m_score = 0; m_clr = '0; m_lives = 3; m_speed = 2;
  endfunction

  function automatic void model_reset();
    model_idle();
    m_state = S_IDLE; m_dx = -1; m_dy = -1; m_cnt = 0;
  endfunction

  function automatic int imin(int a, int b);
    return (a < b) ? a : b;
  endfunction

  function automatic void model_step();
    int c0, n_new, ndx, ndy, spd;
    bit fx, fy, pad;
    logic [1:0] code;
    if (!i_rst_n) begin
      model_reset();
      return;
    end
    c0    = m_cnt & 1;
    m_cnt = (m_cnt + 1) & 16'hFFFF;
    if (!i_mode || m_state == S_IDLE) begin
      model_idle();
      m_state = i_mode ? S_SERVE : S_IDLE;
      return;
    end
    case (m_state)
      S_SERVE: begin
        m_x = 320; m_y = 240; m_dy = -1; m_speed = 2;
        if (i_serve) begin
          m_dx = c0 ? 1 : -1;
          m_state = S_PLAY;
        end
      end
      S_PLAY: if (i_ani_stb) begin
        n_new = 0; fx = 0; fy = 0;
        for (int k = 0; k < NB; k++) begin
          code = i_hit[2*k +: 2];
          if (code != 2'b00 && !m_clr[k]) begin
            n_new++;
            m_clr[k] = 1'b1;
            if (code[0]) fy = 1;
            if (code[1]) fx = 1;
          end
        end
        m_score = imin(m_score + 5 * n_new, 65535);
        ndx = fx ? -m_dx : m_dx;
        ndy = fy ? -m_dy : m_dy;
        pad = (m_dy == 1) && (m_y + H >= 440) && (m_y + H <= 450) &&
              (m_x - H <= int'(i_pad_x2)) && (m_x + H >= int'(i_pad_x1));
        if (pad) begin
          ndy = -1;
          if (i_com == 2'b01) ndx = 1;
          if (i_com == 2'b10) ndx = -1;
        end
        if (m_x <= 9)   ndx = 1;
        if (m_x >= 631) ndx = -1;
        if (m_y <= 9)   ndy = 1;
        m_dx = ndx; m_dy = ndy;
        spd = m_speed;
`ifdef SPEED_RAMP_EN
        if (pad) m_speed = imin(m_speed + 1, 7);
`endif
        if (&m_clr) begin
          m_state = S_WON;
        end else if (m_y + H >= 479) begin
          m_lives--;
          if (m_lives == 0) m_state = S_LOST;
          else begin
            m_state = S_SERVE; m_x = 320; m_y = 240;
          end
        end else begin
          m_x = m_x + ndx * spd;
          if (m_x < 8)   m_x = 8;
          if (m_x > 631) m_x = 631;
          m_y = m_y + ndy * spd;
          if (m_y < 8)   m_y = 8;
        end
      end
      default: if (i_serve) m_state = S_IDLE;
    endcase
  endfunction

  task automatic tick(input logic rst_n, input logic mode, input logic serve,
                      input logic stb, input int p1, input int p2,
                      input logic [1:0] com, input logic [2*NB-1:0] hit);
    exp_t e;
    @(negedge clk);
    i_rst_n = rst_n; i_mode = mode; i_serve = serve; i_ani_stb = stb;
    i_pad_x1 = 12'((p1 < 0) ? 0 : (p1 > 4095 ? 4095 : p1));
    i_pad_x2 = 12'((p2 < 0) ? 0 : (p2 > 4095 ? 4095 : p2));
    i_com = com; i_hit = hit;
    model_step();
    e.x = 12'(m_x); e.y = 12'(m_y); e.clr = m_clr; e.score = 16'(m_score);
    e.lives = 4'(m_lives); e.st = 3'(m_state);
    q.push_back(e);
    cyc++;
  endtask

  // Play cycle with the paddle out of reach.
  task automatic play(input logic serve, input logic stb, input logic [2*NB-1:0] hit);
    tick(1'b1, 1'b1, serve, stb, 4000, 4000, 2'b00, hit);
  endtask

  function automatic logic [2*NB-1:0] one_hit(input int k, input logic [1:0] code);
    logic [2*NB-1:0] h;
    h = '0;
    h[2*k +: 2] = code;
    return h;
  endfunction

  function automatic logic [2*NB-1:0] rand_hit();
    logic [2*NB-1:0] h;
    int k;
    h = '0;
    if ($urandom_range(7) == 0) begin
      k = $urandom_range(NB - 1);
      h[2*k +: 2] = 2'($urandom_range(3, 1));
    end
    if ($urandom_range(39) == 0) begin
      k = $urandom_range(NB - 1);
      h[2*k +: 2] = 2'($urandom_range(3, 1));
    end
    return h;
  endfunction

  // Monitor: one comparison per presented cycle, expected values from the queue.
  initial begin
    exp_t e;
    logic [11:0] ex1, ex2, ey1, ey2;
    logic ewin, elose;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        ex1 = e.x - 12'(H); ex2 = e.x + 12'(H);
        ey1 = e.y - 12'(H); ey2 = e.y + 12'(H);
        ewin = (e.st == 3'(S_WON)); elose = (e.st == 3'(S_LOST));
        total++;
        if ({o_x, o_y, o_x1, o_x2, o_y1, o_y2, o_cleared, o_score, o_lives, o_state, o_win, o_lose}
            !== {e.x, e.y, ex1, ex2, ey1, ey2, e.clr, e.score, e.lives, e.st, ewin, elose}) begin
          bad++;
          $display("FAIL outputs cyc=%0d got x=%0d y=%0d x1=%0d x2=%0d y1=%0d y2=%0d clr=%h score=%0d lives=%0d st=%0d win=%b lose=%b | need x=%0d y=%0d x1=%0d x2=%0d y1=%0d y2=%0d clr=%h score=%0d lives=%0d st=%0d win=%b lose=%b",
                   cyc, o_x, o_y, o_x1, o_x2, o_y1, o_y2, o_cleared, o_score, o_lives, o_state, o_win, o_lose,
                   e.x, e.y, ex1, ex2, ey1, ey2, e.clr, e.score, e.lives, e.st, ewin, elose);
        end
      end
    end
  end

  initial begin
    int budget;
    int off1, off2;
    logic [2*NB-1:0] hit;
    model_reset();

    // Reset with the mode already on, then IDLE -> SERVE.
    repeat (3) tick(1'b0, 1'b1, 1'b0, 1'b1, 0, 4095, 2'b01, '1);
    tick(1'b1, 1'b1, 1'b0, 1'b0, 4000, 4000, 2'b00, '0);
    repeat (3) play(1'b0, 1'b1, '0);

    // Brick 4 once, the same hit again, then bricks 1 and 2 together.
    play(1'b1, 1'b0, '0);
    repeat (5) play(1'b0, 1'b1, '0);
    play(1'b0, 1'b1, one_hit(4, 2'b01));
    repeat (4) play(1'b0, 1'b1, '0);
    play(1'b0, 1'b1, one_hit(4, 2'b01));
    repeat (4) play(1'b0, 1'b1, '0);
    play(1'b0, 1'b1, one_hit(1, 2'b01) | one_hit(2, 2'b01));
    play(1'b0, 1'b0, one_hit(3, 2'b11));
    repeat (3) play(1'b0, 1'b1, one_hit(5, 2'b10));

    // Lose all three balls, then serve back to IDLE.
    budget = 3000;
    while (m_state != S_LOST && budget > 0) begin
      play(m_state == S_SERVE, 1'b1, '0);
      budget--;
    end
    if (budget == 0) begin
      bad++;
      $display("FAIL lose_all_budget got budget=%0d need >0", budget);
    end
    repeat (3) play(1'b0, 1'b1, '0);
    play(1'b1, 1'b0, '0);
    play(1'b0, 1'b0, '0);

    // Paddle spanning the screen with left motion: repeated bounces and ramp.
    play(1'b0, 1'b0, '0);
    play(1'b1, 1'b0, '0);
    repeat (1500) tick(1'b1, 1'b1, 1'b0, 1'b1, 0, 4095, 2'b10, '0);

    // Clear every brick on the strobe that would also lose the ball.
    tick(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 2'b00, '0);
    play(1'b0, 1'b0, '0);
    play(1'b1, 1'b0, '0);
    budget = 500;
    while (m_y + H < 479 && budget > 0) begin
      play(1'b0, 1'b1, '0);
      budget--;
    end
    for (int k = 0; k < NB; k++) hit[2*k +: 2] = 2'($urandom_range(3, 1));
    play(1'b0, 1'b1, hit);
    repeat (3) play(1'b0, 1'b1, '0);
    play(1'b1, 1'b0, '0);

    // Reset in the middle of play.
    play(1'b0, 1'b0, '0);
    play(1'b1, 1'b0, '0);
    repeat (20) play(1'b0, 1'b1, one_hit(7, 2'b10));
    tick(1'b0, 1'b1, 1'b1, 1'b1, 0, 4095, 2'b01, '1);
    repeat (2) play(1'b0, 1'b1, '0);

    // Randomised play.
    for (int n = 0; n < 40000; n++) begin
      logic rst_n, mode, serve, stb;
      int p1, p2;
      rst_n = ($urandom_range(4999) != 0);
      mode  = ($urandom_range(1999) != 0);
      stb   = ($urandom_range(9) < 7);
      case (m_state)
        S_SERVE, S_WON, S_LOST: serve = ($urandom_range(9) == 0);
        default:                serve = ($urandom_range(19) == 0);
      endcase
      if ($urandom_range(1) == 0) begin
        off1 = $urandom_range(30); off2 = $urandom_range(30);
        p1 = m_x - off1; p2 = m_x + off2;
      end else begin
        p1 = $urandom_range(639);
        p2 = p1 + $urandom_range(120);
      end
      tick(rst_n, mode, serve, stb, p1, p2, 2'($urandom_range(3)), rand_hit());
    end

    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      bad++;
      $display("FAIL queue_drain got left=%0d need 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ball_ctrl.md
# ball_ctrl

Parametrised successor to the single-ball square animator: moves one square ball per animation strobe, reflects it off walls, the paddle and an N-block brick field, and owns the full game flow. Game flow covers serve, lives, score, per-block clear flags, and the win/lose decision. It sits between the paddle/brick collision logic (inputs) and the VGA sprite drawer and score display (outputs).

## Interface
Parameters:
- N_BLOCKS, 22: number of bricks; i_hit carries 2 bits per brick.
- H_SIZE, 8: half ball width.
- D_WIDTH, 640 / D_HEIGHT, 480: display size.
- IX, 320 / IY, 240: serve position (ball centre).
- PY, 440 / PH, 10: paddle top y and paddle height.
- SPEED0, 2: initial per-axis step (pixels/strobe).
- MAX_SPEED, 7: step ceiling, ≤15.
- LIVES, 3: balls per game, 1..15.
- SCORE_PER_BLOCK, 5: points per cleared brick.

Ports:
- i_clk  in  1  system clock.
- i_rst_n  in  1  reset; synchronous, active-low.
- i_mode  in  1  game mode active; low forces IDLE.
- i_serve  in  1  one-cycle pulse; launches ball.
- i_ani_stb  in  1  frame strobe, one cycle per frame.
- i_pad_x1, i_pad_x2  in  12  paddle left/right edge.
- i_com  in  2  paddle motion: 01 right, 10 left, else none.
- i_hit  in  2*N_BLOCKS  per brick [2k+1:2k]: 01 top/bottom, 10 side, 11 corner, 00 none.
- o_x, o_y  out  12  ball centre, registered.
- o_x1, o_x2, o_y1, o_y2  out  12  ball edges = centre ∓/± H_SIZE, combinational.
- o_cleared  out  N_BLOCKS  sticky per-brick cleared flags.
- o_score  out  16  saturating score.
- o_lives  out  4  remaining balls.
- o_state  out  3  FSM state encoding.
- o_win, o_lose  out  1  level, held until leaving WON/LOST_ALL.

## Operation
- FSM states: IDLE=0, SERVE=1, PLAY=2, WON=3, LOST_ALL=4.
- IDLE: ball at (IX,IY), score 0, o_cleared 0, lives=LIVES, speed=SPEED0. Goes to SERVE when i_mode=1.
- SERVE: ball parked at (IX,IY), y_dir=up. On i_serve, x_dir = bit 0 of a free-running 16-bit counter; go to PLAY.
- PLAY: acts only on cycles with i_ani_stb=1.
  - Newly hit bricks = hit code ≠00 and o_cleared bit =0. Hits on already-cleared bricks are ignored.
  - y_dir flips once if any new hit has bit0 set; x_dir flips once if any has bit1 set. Multiple hits never double-flip.
  - Score += SCORE_PER_BLOCK × popcount(new hits); saturates at 0xFFFF. Matching o_cleared bits are set.
  - Walls: x ≤ H_SIZE+1 → x_dir=right; x ≥ D_WIDTH-H_SIZE-1 → x_dir=left; y ≤ H_SIZE+1 → y_dir=down.
  - Paddle hit: y_dir=down, PY ≤ o_y2 ≤ PY+PH, o_x1 ≤ i_pad_x2, o_x2 ≥ i_pad_x1 → y_dir=up. i_com 01 forces x_dir=right, 10 forces left.
  - Wall/paddle rules override brick flips on the same axis.
  - Position steps with the updated directions. Result is clamped to [H_SIZE, D_WIDTH-1-H_SIZE] horizontally and ≥ H_SIZE vertically.
  - Bottom: o_y2 ≥ D_HEIGHT-1 → lives -1. If the result is 0, go to LOST_ALL; else go to SERVE with ball reset and speed=SPEED0. Score and o_cleared are kept.
  - All o_cleared =1 (after this strobe's update) → WON. WON takes precedence over a same-strobe bottom loss.
- WON/LOST_ALL: ball frozen. On i_serve, go to IDLE.
- i_mode=0 in any state → IDLE next cycle.

## Timing
- Reset values: state IDLE, o_x=IX, o_y=IY, o_score 0, o_cleared 0, o_lives LIVES, o_win 0, o_lose 0, speed SPEED0, counter 0.
- Reset overrides all other inputs, including mid-PLAY.
- Every PLAY update lands one cycle after the i_ani_stb cycle. Non-strobe cycles hold all state.
- i_hit is sampled only on strobe cycles; the collision logic must hold it valid during the strobe.
- i_serve outside SERVE/WON/LOST_ALL is ignored.
- Edge outputs follow o_x/o_y combinationally, 12-bit wrap arithmetic.

## Configuration
- SPEED_RAMP_EN defined: every paddle hit increments both axis steps by 1, up to MAX_SPEED. Steps reset to SPEED0 on serve.
- SPEED_RAMP_EN undefined: steps stay at SPEED0 permanently; no ramp logic is built.

## Test plan
- Reset with i_mode=1 → state SERVE one cycle later, o_x=320, o_y=240, o_lives=3, o_score=0.
- Serve, then drive i_hit brick 4 =01 for one strobe → o_cleared[4]=1, o_score=5, y_dir flips. Repeat the same hit → no score change, no flip.
- Bricks 1 and 2 =01 on one strobe → o_score +10, y_dir flips exactly once.
- Ball falls past the paddle three times → o_lives 2, 1, then state LOST_ALL with o_lose=1. i_serve → IDLE.
- Paddle hit with i_com=10 → y_dir up, x_dir left. With SPEED_RAMP_EN defined, step goes 2→3. After 10 hits, step is 7 (capped).
- Clear all 22 bricks on the same strobe the ball touches bottom → WON, o_win=1, o_lives unchanged. Assert i_rst_n=0 mid-PLAY → all reset values next cycle.
